// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl
// Decodes single-byte UART commands, holds the trigger configuration and
// sequences pre-trigger fill, trigger detection and post-trigger capture of
// ADC sample pairs into the capture RAM. Completion and status bytes are
// returned through a one-entry TX holding register.
module scope_capture_ctrl #(
    parameter int SAMPLE_W = 14,
    parameter int ADDR_W   = 12,
    parameter int PRETRIG  = 256,
    parameter int RX_TMO   = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [SAMPLE_W-1:0]   smp_a,
    input  logic [SAMPLE_W-1:0]   smp_b,
    input  logic                  smp_valid,
    output logic                  buf_we,
    output logic [ADDR_W-1:0]     buf_addr,
    output logic [2*SAMPLE_W-1:0] buf_din,
    output logic [ADDR_W-1:0]     trig_addr,
    output logic                  armed,
    output logic                  busy
);

    // Largest post-trigger count that still fits in the ring alongside the pre-trigger history.
    localparam int POST_MAX = (2**ADDR_W) - PRETRIG - 1;
    // Gap counter width; RX_TMO must be at least 2.
    localparam int TMO_W    = $clog2(RX_TMO);

    localparam logic [7:0] CMD_ARM  = 8'h41;
    localparam logic [7:0] CMD_RISE = 8'h52;
    localparam logic [7:0] CMD_FALL = 8'h46;
    localparam logic [7:0] CMD_STOP = 8'h53;
    localparam logic [7:0] CMD_STAT = 8'h3F;
    localparam logic [7:0] TX_DONE  = 8'h44;
    localparam logic [3:0] PL_LAST  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } cap_state_t;

    typedef enum logic {
        PS_IDLE    = 1'b0,
        PS_PAYLOAD = 1'b1
    } ps_state_t;

    // Saturate a requested post-trigger count to what the ring can hold.
    function automatic logic [ADDR_W-1:0] clamp_post(input logic [15:0] req);
        logic [ADDR_W-1:0] res;
        if (req > 16'(POST_MAX)) begin
            res = ADDR_W'(POST_MAX);
        end else begin
            res = ADDR_W'(req);
        end
        return res;
    endfunction

    cap_state_t          cap_state_r, cap_state_s;
    ps_state_t           ps_state_r, ps_state_s;
    logic [3:0]          pl_idx_r, pl_idx_s;
    logic [TMO_W-1:0]    tmo_cnt_r, tmo_cnt_s;

    logic                pl_fall_r;
    logic [7:0]          pl_lvl_hi_r;
    logic [SAMPLE_W-1:0] pl_level_r;
    logic                pl_chan_r;
    logic [15:0]         pl_post_r;

    logic [SAMPLE_W-1:0] cfg_level_r;
    logic                cfg_fall_r;
    logic                cfg_chan_r;
    logic [ADDR_W-1:0]   cfg_post_r;

    logic [ADDR_W-1:0]   wr_addr_r;
    logic [ADDR_W-1:0]   fill_r;
    logic [ADDR_W-1:0]   post_cnt_r;
    logic [SAMPLE_W-1:0] prev_r;
    logic                have_p_r;
    logic [ADDR_W-1:0]   trig_addr_r;
    logic                armed_r;
    logic                busy_r;

    logic [7:0]          tx_data_r;
    logic                tx_valid_r;
    logic                tx_done_r;

    logic                cmd_byte_s, pl_byte_s;
    logic                cmd_arm_s, cmd_stop_s, cmd_stat_s;
    logic                commit_s;
    logic                wr_en_s;
    logic                trig_hit_s;
    logic                done_evt_s;
    logic                hold_done_s;
    logic [SAMPLE_W-1:0] sel_smp_s;
    logic [2:0]          state_code_s;

    // Command strobes are only decoded while no payload is being collected.
    always_comb begin
        cmd_byte_s   = rx_valid && (ps_state_r == PS_IDLE);
        pl_byte_s    = rx_valid && (ps_state_r == PS_PAYLOAD);
        cmd_arm_s    = cmd_byte_s && (rx_data == CMD_ARM);
        cmd_stop_s   = cmd_byte_s && (rx_data == CMD_STOP);
        cmd_stat_s   = cmd_byte_s && (rx_data == CMD_STAT);
        commit_s     = pl_byte_s && (pl_idx_r == PL_LAST) &&
                       ((cap_state_r == ST_IDLE) || (cap_state_r == ST_DONE));
        wr_en_s      = smp_valid && !cmd_stop_s &&
                       ((cap_state_r == ST_PRE) || (cap_state_r == ST_WAIT) ||
                        (cap_state_r == ST_POST));
        hold_done_s  = tx_valid_r && tx_done_r && !tx_ready;
        state_code_s = cap_state_r;
    end

    // Trigger comparator on the selected channel against the previous valid sample.
    always_comb begin
        if (cfg_chan_r) begin
            sel_smp_s = smp_b;
        end else begin
            sel_smp_s = smp_a;
        end
        trig_hit_s = 1'b0;
        if ((cap_state_r == ST_WAIT) && smp_valid && have_p_r && !cmd_stop_s && !cmd_arm_s) begin
            if (cfg_fall_r) begin
                trig_hit_s = (prev_r > cfg_level_r) && (sel_smp_s <= cfg_level_r);
            end else begin
                trig_hit_s = (prev_r < cfg_level_r) && (sel_smp_s >= cfg_level_r);
            end
        end else begin
            trig_hit_s = 1'b0;
        end
    end

    // Capture FSM next state: stop beats arm, arm restarts from any state.
    always_comb begin
        cap_state_s = cap_state_r;
        if (cmd_stop_s) begin
            cap_state_s = ST_IDLE;
        end else if (cmd_arm_s) begin
            cap_state_s = ST_PRE;
        end else begin
            case (cap_state_r)
                ST_PRE: begin
                    if (smp_valid && (fill_r == ADDR_W'(PRETRIG - 1))) begin
                        cap_state_s = ST_WAIT;
                    end else begin
                        cap_state_s = ST_PRE;
                    end
                end
                ST_WAIT: begin
                    if (trig_hit_s) begin
                        cap_state_s = ST_POST;
                    end else begin
                        cap_state_s = ST_WAIT;
                    end
                end
                ST_POST: begin
                    if (smp_valid && (post_cnt_r == {ADDR_W{1'b0}})) begin
                        cap_state_s = ST_DONE;
                    end else begin
                        cap_state_s = ST_POST;
                    end
                end
                ST_IDLE: cap_state_s = ST_IDLE;
                ST_DONE: cap_state_s = ST_DONE;
                default: cap_state_s = ST_IDLE;
            endcase
        end
        done_evt_s = (cap_state_r == ST_POST) && (cap_state_s == ST_DONE);
    end

    // Parser next state: payload index and inter-byte gap timeout.
    always_comb begin
        ps_state_s = ps_state_r;
        pl_idx_s   = pl_idx_r;
        tmo_cnt_s  = tmo_cnt_r;
        case (ps_state_r)
            PS_IDLE: begin
                if (cmd_byte_s && ((rx_data == CMD_RISE) || (rx_data == CMD_FALL))) begin
                    ps_state_s = PS_PAYLOAD;
                    pl_idx_s   = 4'd0;
                    tmo_cnt_s  = {TMO_W{1'b0}};
                end else begin
                    ps_state_s = PS_IDLE;
                end
            end
            PS_PAYLOAD: begin
                if (rx_valid) begin
                    tmo_cnt_s = {TMO_W{1'b0}};
                    if (pl_idx_r == PL_LAST) begin
                        ps_state_s = PS_IDLE;
                    end else begin
                        pl_idx_s = pl_idx_r + 4'd1;
                    end
                end else if (tmo_cnt_r == TMO_W'(RX_TMO - 1)) begin
                    ps_state_s = PS_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            default: ps_state_s = PS_IDLE;
        endcase
    end

    // Parser registers and payload shadow; the live config only changes on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_state_r  <= PS_IDLE;
            pl_idx_r    <= 4'd0;
            tmo_cnt_r   <= {TMO_W{1'b0}};
            pl_fall_r   <= 1'b0;
            pl_lvl_hi_r <= 8'h00;
            pl_level_r  <= {SAMPLE_W{1'b0}};
            pl_chan_r   <= 1'b0;
            pl_post_r   <= 16'h0000;
            cfg_level_r <= {SAMPLE_W{1'b0}};
            cfg_fall_r  <= 1'b0;
            cfg_chan_r  <= 1'b0;
            cfg_post_r  <= ADDR_W'(POST_MAX);
        end else begin
            ps_state_r <= ps_state_s;
            pl_idx_r   <= pl_idx_s;
            tmo_cnt_r  <= tmo_cnt_s;
            if (cmd_byte_s && ((rx_data == CMD_RISE) || (rx_data == CMD_FALL))) begin
                pl_fall_r <= (rx_data == CMD_FALL);
            end
            if (pl_byte_s) begin
                case (pl_idx_r)
                    4'd0:    pl_lvl_hi_r     <= rx_data;
                    4'd1:    pl_level_r      <= SAMPLE_W'({pl_lvl_hi_r, rx_data});
                    4'd2:    pl_chan_r       <= rx_data[0];
                    4'd3:    pl_post_r[15:8] <= rx_data;
                    4'd4:    pl_post_r[7:0]  <= rx_data;
                    default: pl_chan_r       <= pl_chan_r;
                endcase
            end
            if (commit_s) begin
                cfg_level_r <= pl_level_r;
                cfg_fall_r  <= pl_fall_r;
                cfg_chan_r  <= pl_chan_r;
                cfg_post_r  <= clamp_post(pl_post_r);
            end
        end
    end

    // Capture state, ring write pointer, fill/post counters and trigger history.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_state_r <= ST_IDLE;
            wr_addr_r   <= {ADDR_W{1'b0}};
            fill_r      <= {ADDR_W{1'b0}};
            post_cnt_r  <= {ADDR_W{1'b0}};
            prev_r      <= {SAMPLE_W{1'b0}};
            have_p_r    <= 1'b0;
            trig_addr_r <= {ADDR_W{1'b0}};
            armed_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cap_state_r <= cap_state_s;
            armed_r     <= (cap_state_s == ST_PRE) || (cap_state_s == ST_WAIT);
            busy_r      <= (cap_state_s == ST_PRE) || (cap_state_s == ST_WAIT) ||
                           (cap_state_s == ST_POST);
            if (cmd_arm_s) begin
                wr_addr_r <= {ADDR_W{1'b0}};
                fill_r    <= {ADDR_W{1'b0}};
                have_p_r  <= 1'b0;
            end else if (wr_en_s) begin
                wr_addr_r <= wr_addr_r + ADDR_W'(1);
                if (cap_state_r == ST_PRE) begin
                    fill_r <= fill_r + ADDR_W'(1);
                end
                if (cap_state_r == ST_WAIT) begin
                    prev_r   <= sel_smp_s;
                    have_p_r <= 1'b1;
                end
                if (trig_hit_s) begin
                    trig_addr_r <= wr_addr_r;
                    post_cnt_r  <= cfg_post_r;
                end else if (cap_state_r == ST_POST) begin
                    post_cnt_r <= post_cnt_r - ADDR_W'(1);
                end
            end
        end
    end

    // One-entry TX holder: an unsent completion byte is never displaced by a status reply.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            tx_done_r  <= 1'b0;
        end else if (done_evt_s) begin
            tx_data_r  <= TX_DONE;
            tx_valid_r <= 1'b1;
            tx_done_r  <= 1'b1;
        end else if (cmd_stat_s && !hold_done_s) begin
            tx_data_r  <= {5'b00000, state_code_s};
            tx_valid_r <= 1'b1;
            tx_done_r  <= 1'b0;
        end else if (tx_valid_r && tx_ready) begin
            tx_valid_r <= 1'b0;
            tx_done_r  <= 1'b0;
        end
    end

    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign buf_we    = wr_en_s;
    assign buf_addr  = wr_addr_r;
    assign buf_din   = wr_en_s ? {smp_b, smp_a} : {(2*SAMPLE_W){1'b0}};
    assign trig_addr = trig_addr_r;
    assign armed     = armed_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Scoreboard bench for scope_capture_ctrl: expected RAM writes and TX bytes are
// queued as stimulus is driven and consumed by monitors on the falling edge.
module tb_scope_capture_ctrl;
    localparam int SAMPLE_W = 14;
    localparam int ADDR_W   = 12;
    localparam int PRETRIG  = 256;
    localparam int RX_TMO   = 64;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [2*SAMPLE_W-1:0] din;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [SAMPLE_W-1:0]   smp_a;
    logic [SAMPLE_W-1:0]   smp_b;
    logic                  smp_valid;
    logic                  buf_we;
    logic [ADDR_W-1:0]     buf_addr;
    logic [2*SAMPLE_W-1:0] buf_din;
    logic [ADDR_W-1:0]     trig_addr;
    logic                  armed;
    logic                  busy;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    int         err_cnt = 0;
    int         chk_cnt = 0;

    scope_capture_ctrl #(
        .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG), .RX_TMO(RX_TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .smp_a(smp_a), .smp_b(smp_b), .smp_valid(smp_valid),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_din(buf_din),
        .trig_addr(trig_addr), .armed(armed), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture RAM write monitor.
    always @(negedge clk) begin
        if (rst == 1'b0 && buf_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                check_val("write_unexpected", 64'(buf_addr), 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check_val("buf_write", 64'({buf_addr, buf_din}), 64'({e.addr, e.din}));
            end
        end
    end

    // UART TX handshake monitor.
    always @(negedge clk) begin
        if (rst == 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_q.size() == 0) begin
                check_val("tx_unexpected", 64'(tx_data), 64'h100);
            end else begin
                logic [7:0] eb;
                eb = tx_q.pop_front();
                check_val("tx_byte", 64'(tx_data), 64'(eb));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [7:0] rd, input logic sv,
                         input logic [SAMPLE_W-1:0] a, input logic [SAMPLE_W-1:0] b);
        rx_valid  = rv;
        rx_data   = rd;
        smp_valid = sv;
        smp_a     = a;
        smp_b     = b;
        cyc();
        rx_valid  = 1'b0;
        smp_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0, {SAMPLE_W{1'b0}}, {SAMPLE_W{1'b0}});
    endtask

    task automatic send_cfg(input logic [7:0] cmd, input logic [15:0] lvl, input logic ch,
                            input logic [15:0] post);
        send(cmd);
        send(lvl[15:8]);
        send(lvl[7:0]);
        send({7'b0000000, ch});
        send(post[15:8]);
        send(post[7:0]);
        repeat (5) send(8'h00);
    endtask

    function automatic logic [2*SAMPLE_W-1:0] pattern(input int mode, input int k);
        logic [SAMPLE_W-1:0] a, b;
        case (mode)
            0: begin
                a = (k < 270) ? {SAMPLE_W{1'b0}} : SAMPLE_W'(k - 270);
                b = a;
            end
            1: begin
                a = SAMPLE_W'(k);
                b = SAMPLE_W'(k * 3);
            end
            2: begin
                a = SAMPLE_W'(k);
                b = (k == 256 || k >= 300) ? 14'h00FF : 14'h0200;
            end
            default: begin
                a = SAMPLE_W'(k);
                b = {SAMPLE_W{1'b0}};
            end
        endcase
        return {b, a};
    endfunction

    // Drives n_drive sample pairs; the first n_wr are expected at addresses 0..n_wr-1.
    task automatic capture(input int mode, input int n_drive, input int n_wr, input int st_k,
                           input logic [7:0] st_exp, input bit exp_done);
        wr_t                   e;
        logic [2*SAMPLE_W-1:0] d;
        logic                  rv;
        for (int k = 0; k < n_drive; k++) begin
            d = pattern(mode, k);
            if (k < n_wr) begin
                e.addr = ADDR_W'(k);
                e.din  = d;
                wr_q.push_back(e);
            end
            rv = (k == st_k);
            if (rv) tx_q.push_back(st_exp);
            if (exp_done && k == n_wr - 1) tx_q.push_back(8'h44);
            drive(rv, rv ? 8'h3F : 8'h00, 1'b1, d[SAMPLE_W-1:0], d[2*SAMPLE_W-1:SAMPLE_W]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_tx_valid"},  64'(tx_valid),  64'd0);
        check_val({tag, "_tx_data"},   64'(tx_data),   64'd0);
        check_val({tag, "_buf_we"},    64'(buf_we),    64'd0);
        check_val({tag, "_buf_addr"},  64'(buf_addr),  64'd0);
        check_val({tag, "_buf_din"},   64'(buf_din),   64'd0);
        check_val({tag, "_trig_addr"}, 64'(trig_addr), 64'd0);
        check_val({tag, "_armed"},     64'(armed),     64'd0);
        check_val({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;
        smp_a     = 14'h1234;
        smp_b     = 14'h0567;
        smp_valid = 1'b1;
        repeat (3) cyc();
        check_all_zero("reset");
        rst       = 1'b0;
        smp_valid = 1'b0;
        cyc();

        // Partial 0x52 payload abandoned by the gap timeout.
        send(8'h52);
        send(8'h00);
        send(8'h10);
        send(8'h01);
        send(8'h00);
        repeat (RX_TMO + 2) cyc();
        tx_q.push_back(8'h00);
        send(8'h3F);
        repeat (2) cyc();

        // Default config cannot trigger; a leaked level would fire near sample 286.
        send(8'h41);
        check_val("arm_armed", 64'(armed), 64'd1);
        check_val("arm_busy",  64'(busy),  64'd1);
        capture(0, 300, 300, 290, 8'h02, 1'b0);
        check_val("wait_armed", 64'(armed), 64'd1);
        drive(1'b1, 8'h53, 1'b1, 14'h0005, 14'h0005);
        check_val("stop_armed", 64'(armed), 64'd0);
        check_val("stop_busy",  64'(busy),  64'd0);
        repeat (5) drive(1'b0, 8'h00, 1'b1, 14'h0009, 14'h0009);
        tx_q.push_back(8'h00);
        send(8'h3F);
        repeat (2) cyc();

        // Rising trigger at 0x0800 on channel A, 15 -> 16 post-trigger writes.
        send_cfg(8'h52, 16'h0800, 1'b0, 16'h000F);
        send(8'h41);
        capture(1, 2075, 2065, 2053, 8'h03, 1'b1);
        check_val("rise_trig_addr", 64'(trig_addr), 64'h800);
        check_val("rise_busy",      64'(busy),      64'd0);
        tx_q.push_back(8'h04);
        send(8'h3F);
        repeat (3) cyc();

        // Falling trigger at 0x0100 on channel B; first WAIT sample must not fire.
        send_cfg(8'h46, 16'h0100, 1'b1, 16'h000F);
        send(8'h41);
        capture(2, 330, 317, -1, 8'h00, 1'b1);
        check_val("fall_trig_addr", 64'(trig_addr), 64'd300);
        repeat (3) cyc();

        // Completion byte held while the transmitter stalls; status must not displace it.
        tx_ready = 1'b0;
        send(8'h41);
        capture(2, 330, 317, -1, 8'h00, 1'b0);
        send(8'h3F);
        cyc();
        check_val("hold_valid", 64'(tx_valid), 64'd1);
        check_val("hold_data",  64'(tx_data),  64'h44);
        tx_q.push_back(8'h44);
        tx_ready = 1'b1;
        repeat (3) cyc();
        check_val("hold_drained", 64'(tx_valid), 64'd0);

        // Reset in the middle of POST, then a clean capture from address 0.
        send_cfg(8'h52, 16'h0120, 1'b0, 16'h0005);
        send(8'h41);
        capture(3, 291, 291, -1, 8'h00, 1'b0);
        check_val("post_busy",  64'(busy),  64'd1);
        check_val("post_armed", 64'(armed), 64'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_all_zero("midrst");
        send_cfg(8'h52, 16'h0120, 1'b0, 16'h0005);
        send(8'h41);
        capture(3, 300, 295, -1, 8'h00, 1'b1);
        check_val("rearm_trig_addr", 64'(trig_addr), 64'd288);
        repeat (5) cyc();

        check_val("wr_q_left", 64'(wr_q.size()), 64'd0);
        check_val("tx_q_left", 64'(tx_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
